frame_secded_rx: RTL and testbench
==================================

// Module: frame_secded_rx
// PURPOSE
//  Receive end of the 14-bit data / 8-bit check-word path: deserialises 22-bit frames
//  (14 data + 8 check) and recomputes the check byte from the received data.
//  Corrects any single-bit error, flags double-bit errors, and delivers the data word
//  over a valid/ready interface. Sits after the serial link, before the consumer.
// PARAMETERS
//  DATA_W   14   data bits per frame (package masks sized to match; fixed)
//  CHK_W    8    check bits per frame (fixed)
// PORTS
//  clk            in   1   single clock; all logic rising-edge
//  rst            in   1   asynchronous, active-high reset
//  s_valid        in   1   s_bit valid this cycle
//  s_sof          in   1   qualifies s_bit as bit 0 of a new frame
//  s_bit          in   1   serial bit; frame order data[0..13], then chk[0..7]
//  s_ready        out  1   receiver accepts s_bit this cycle
//  m_valid        out  1   decoded word available
//  m_ready        in   1   consumer accepts word
//  m_data         out  14  corrected data
//  m_err_corr     out  1   single-bit error corrected (data or check bit)
//  m_err_uncorr   out  1   uncorrectable error; m_data is raw received data
//  abort_cnt      out  8   saturating count of frames restarted by s_sof mid-frame
// BEHAVIOUR
//  - Reset: state IDLE, bit counter 0, s_ready=1, m_valid=0, m_data=0,
//    both error flags 0, abort_cnt=0.
//  - Beat accepted when s_valid && s_ready.
//  - FSM:
//    IDLE  -> SHIFT on an accepted beat with s_sof=1 (bit stored, cnt=1).
//             Beats with s_sof=0 are discarded.
//    SHIFT -> shifts in accepted beats. After bit 21 is accepted -> EVAL.
//    EVAL  -> one cycle: registers syndrome = chk_rx ^ f(data_rx) and the
//             corrected word -> HOLD.
//    HOLD  -> m_valid=1; outputs stable until m_ready; then -> IDLE.
//  - s_ready=1 in IDLE/SHIFT, 0 in EVAL/HOLD.
//  - Latency: last bit accepted at edge t -> m_valid high after edge t+2.
//  - Back-to-back: a new s_sof is accepted the cycle after the m_valid&&m_ready handshake.
//  - Check function: chk[k] = ^(data & CHK_MASK[k]).
//    Column j of CHK_MASK (data bit j) is distinct, odd weight 3.
//  - Syndrome decode:
//    0 -> clean.
//    == column j -> flip data[j], m_err_corr=1.
//    one-hot -> check-bit error, data unchanged, m_err_corr=1.
//    any other value -> m_err_uncorr=1.
//  - s_sof accepted while in SHIFT (cnt!=0): discard partial frame, restart with this
//    bit as bit 0, abort_cnt++ (saturates at 255).
//  - s_sof=1 on bits 1..21 is otherwise illegal; it restarts the frame exactly as above.
//  - s_valid while s_ready=0: ignored, no state change.
//  - m_valid never drops without m_ready; outputs hold while stalled.
//  - rst mid-frame or mid-HOLD: immediate return to reset values; pending word lost.
// STRUCTURE
//  - Shared package frame_secded_pkg:
//    DATA_W, CHK_W, CHK_MASK[CHK_W] (14-bit masks), state enum {IDLE,SHIFT,EVAL,HOLD},
//    function chk_calc(data) -> 8-bit check, function syn_decode(syn) -> {flip_idx, corr, uncorr}.
//  - The same package is used by the transmit-side encoder and the testbench model.
//  - One sub-module: frame_secded_syndrome (combinational: data,chk -> syndrome, flip
//    vector, flags), instantiated once in EVAL.
//  - The top module holds the FSM, shift register, counters and output register.
// TESTING
//  1 Clean frame: data 14'h2A5C, chk=chk_calc(data), no stalls
//    -> m_data=14'h2A5C, both flags 0, m_valid at t+2.
//  2 Data single error: data 14'h0000, chk 8'h00, bit 3 flipped in transit
//    -> m_data=14'h0000, m_err_corr=1.
//  3 Check single error: data 14'h3FFF, correct chk with chk[5] inverted
//    -> m_data=14'h3FFF, m_err_corr=1, m_err_uncorr=0.
//  4 Double error: data 14'h1234 with bits 0 and 9 flipped
//    -> m_err_uncorr=1, m_data=14'h1235^14'h0200 (raw).
//  5 Abort: s_sof after 10 bits, then a full clean frame 14'h0F0F
//    -> one output word 14'h0F0F, abort_cnt=1.
//  6 Backpressure/reset: hold m_ready=0 for 5 cycles -> outputs stable, s_ready=0;
//    assert rst mid-SHIFT -> m_valid=0, s_ready=1, next frame decodes cleanly.

Source files
------------

// File: rtl/frame_secded_pkg.sv
// Shared definitions for the 14-bit data / 8-bit check-word SECDED path.
// Used by the receive decoder, the transmit-side encoder and the testbench model.
//   CHK_MASK[k] : data bits that feed check bit k
//   chk_calc    : check byte of a data word
//   syn_decode  : syndrome -> {flip_idx, flip, corr, uncorr}
package frame_secded_pkg;

    localparam int DATA_W  = 14;
    localparam int CHK_W   = 8;
    localparam int FRAME_W = DATA_W + CHK_W;

    // Every data-bit column is a distinct weight-3 byte, so a single data error
    // gives an odd-weight syndrome matching one column, a check-bit error gives a
    // one-hot syndrome, and any double error gives a nonzero even-weight syndrome.
    // Columns j0..j13: 07 0B 0D 0E 13 15 16 19 1A 1C 70 B0 D0 E0
    localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
        14'h3800,   // k7
        14'h3400,   // k6
        14'h2C00,   // k5
        14'h1FF0,   // k4
        14'h038E,   // k3
        14'h026D,   // k2
        14'h015B,   // k1
        14'h00B7    // k0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EVAL  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] flip_idx;
        logic       flip;
        logic       corr;
        logic       uncorr;
    } syn_dec_t;

    function automatic logic [CHK_W-1:0] chk_calc(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        for (int k = 0; k < CHK_W; k++) begin
            chk[k] = ^(data & CHK_MASK[k]);
        end
        return chk;
    endfunction

    function automatic syn_dec_t syn_decode(input logic [CHK_W-1:0] syn);
        syn_dec_t         dec;
        logic [CHK_W-1:0] col;
        dec = '0;
        if (syn == '0) begin
            dec = '0;
        end else if ($onehot(syn)) begin
            dec.corr = 1'b1;
        end else begin
            dec.uncorr = 1'b1;
            for (int j = 0; j < DATA_W; j++) begin
                for (int k = 0; k < CHK_W; k++) begin
                    col[k] = CHK_MASK[k][j];
                end
                if (syn == col) begin
                    dec.flip_idx = 4'(j);
                    dec.flip     = 1'b1;
                    dec.corr     = 1'b1;
                    dec.uncorr   = 1'b0;
                end
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/frame_secded_syndrome.sv
// Combinational syndrome evaluation for one received frame.
//   data     : received data word
//   chk      : received check byte
//   syndrome : chk ^ chk_calc(data)
//   flip_vec : one-hot data-bit correction mask (zero when no data bit is flipped)
//   corr     : single-bit error (data or check bit)
//   uncorr   : uncorrectable error
module frame_secded_syndrome
    import frame_secded_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output logic [CHK_W-1:0]  syndrome,
    output logic [DATA_W-1:0] flip_vec,
    output logic              corr,
    output logic              uncorr
);

    syn_dec_t dec;

    always_comb begin
        syndrome = chk ^ chk_calc(data);
        dec      = syn_decode(syndrome);
        flip_vec = dec.flip ? (DATA_W'(1) << dec.flip_idx) : '0;
        corr     = dec.corr;
        uncorr   = dec.uncorr;
    end

endmodule

// File: rtl/frame_secded_rx.sv
// Receive side of the SECDED serial link: deserialises 22-bit frames
// (data[0..13] then chk[0..7]), corrects single-bit errors, flags double errors
// and hands the word to the consumer over valid/ready.
//   clk, rst      : clock, asynchronous active-high reset
//   s_valid/s_sof/s_bit/s_ready : serial input beat interface
//   m_valid/m_ready/m_data/m_err_corr/m_err_uncorr : decoded word interface
//   abort_cnt     : saturating count of frames restarted by s_sof mid-frame
module frame_secded_rx
    import frame_secded_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_sof,
    input  logic              s_bit,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_err_corr,
    output logic              m_err_uncorr,
    output logic [7:0]        abort_cnt
);

    state_t              state_q, state_d;
    logic [4:0]          cnt_q;
    logic                accept;
    logic                m_valid_q;
    logic [FRAME_W-1:0]  frame_p0;
    logic [DATA_W-1:0]   data_p1;
    logic                corr_p1, uncorr_p1;
    logic [CHK_W-1:0]    syndrome;
    logic [DATA_W-1:0]   flip_vec;
    logic                corr, uncorr;

    assign s_ready = (state_q == IDLE) || (state_q == SHIFT);
    assign accept  = s_valid && s_ready;
    assign m_valid = m_valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept && s_sof) state_d = SHIFT;
            SHIFT: if (accept && !s_sof && cnt_q == 5'd21) state_d = EVAL;
            EVAL:  state_d = HOLD;
            HOLD:  if (m_valid_q && m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            abort_cnt    <= '0;
            m_valid_q    <= 1'b0;
            m_data       <= '0;
            m_err_corr   <= 1'b0;
            m_err_uncorr <= 1'b0;
        end else begin
            state_q <= state_d;
            // s_sof always restarts the count; plain beats only count inside a frame.
            if (accept) begin
                if (s_sof) begin
                    cnt_q <= 5'd1;
                end else if (state_q == SHIFT) begin
                    cnt_q <= (cnt_q == 5'd21) ? 5'd0 : cnt_q + 5'd1;
                end
            end
            if (accept && s_sof && state_q == SHIFT && abort_cnt != 8'hFF) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
            // First HOLD cycle loads the output register; it then holds until taken.
            if (state_q == HOLD) begin
                if (!m_valid_q) begin
                    m_valid_q    <= 1'b1;
                    m_data       <= data_p1;
                    m_err_corr   <= corr_p1;
                    m_err_uncorr <= uncorr_p1;
                end else if (m_ready) begin
                    m_valid_q <= 1'b0;
                end
            end
        end
    end

    // Stage p0: serial shift register, first bit ends up in frame_p0[0]
    always_ff @(posedge clk) begin
        if (accept && (s_sof || state_q == SHIFT)) begin
            frame_p0 <= {s_bit, frame_p0[FRAME_W-1:1]};
        end
    end

    frame_secded_syndrome u_syndrome (
        .data     (frame_p0[DATA_W-1:0]),
        .chk      (frame_p0[FRAME_W-1:DATA_W]),
        .syndrome (syndrome),
        .flip_vec (flip_vec),
        .corr     (corr),
        .uncorr   (uncorr)
    );

    // Stage p1: corrected word and error flags captured in EVAL
    always_ff @(posedge clk) begin
        if (state_q == EVAL) begin
            data_p1   <= frame_p0[DATA_W-1:0] ^ flip_vec;
            corr_p1   <= corr;
            uncorr_p1 <= uncorr;
        end
    end

endmodule

// File: tb/tb_frame_secded_rx.sv
module tb_frame_secded_rx;
    import frame_secded_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_sof = 1'b0;
    logic              s_bit = 1'b0;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_err_corr;
    logic              m_err_uncorr;
    logic [7:0]        abort_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              corr;
        logic              uncorr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    frame_secded_rx dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_sof        (s_sof),
        .s_bit        (s_bit),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_err_corr   (m_err_corr),
        .m_err_uncorr (m_err_uncorr),
        .abort_cnt    (abort_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic sof);
        s_valid = 1'b1;
        s_bit   = b;
        s_sof   = sof;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_bits(input logic [FRAME_W-1:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i], i == 0);
    endtask

    // Sends {chk, data} ^ flip and records what the decoder must deliver.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic [CHK_W-1:0] chk,
                              input logic [FRAME_W-1:0] flip,
                              input logic [DATA_W-1:0] exp_data,
                              input logic exp_corr, input logic exp_uncorr);
        exp_t e;
        e.data   = exp_data;
        e.corr   = exp_corr;
        e.uncorr = exp_uncorr;
        sb_q.push_back(e);
        send_bits({chk, data} ^ flip, FRAME_W);
    endtask

    // Called at the falling edge right after the last bit was accepted.
    task automatic recv(input string tag, input int stall, input bit junk);
        int                n;
        exp_t              e;
        logic [DATA_W-1:0] held;
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 2);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, m_data, e.data);
            check({tag, "_corr"}, m_err_corr, e.corr);
            check({tag, "_uncorr"}, m_err_uncorr, e.uncorr);
        end
        held = m_data;
        for (int i = 0; i < stall; i++) begin
            m_ready = 1'b0;
            if (junk) begin
                s_valid = 1'b1;
                s_sof   = 1'b1;
                s_bit   = 1'b1;
            end
            @(negedge clk);
            check({tag, "_stall_valid"}, m_valid, 1);
            check({tag, "_stall_data"}, m_data, held);
            check({tag, "_stall_sready"}, s_ready, 0);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_after_valid"}, m_valid, 0);
        check({tag, "_after_sready"}, s_ready, 1);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [CHK_W-1:0]  c;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sready", s_ready, 1);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_corr", m_err_corr, 0);
        check("rst_uncorr", m_err_uncorr, 0);
        check("rst_abort", abort_cnt, 0);

        // Check-byte function: single-bit data words give the column values
        check("chk_col0", chk_calc(14'h0001), 8'h07);
        check("chk_col13", chk_calc(14'h2000), 8'hE0);

        // Beats without s_sof in IDLE are discarded
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("idle_discard_sready", s_ready, 1);
        check("idle_discard_abort", abort_cnt, 0);

        // 1 Clean frame
        d = 14'h2A5C;
        send_frame(d, chk_calc(d), '0, d, 1'b0, 1'b0);
        recv("clean", 0, 1'b0);

        // 2 Single data-bit error, bit 3
        send_frame(14'h0000, 8'h00, 22'(1) << 3, 14'h0000, 1'b1, 1'b0);
        recv("data_err", 0, 1'b0);

        // 3 Single check-bit error, chk[5]
        d = 14'h3FFF;
        c = chk_calc(d) ^ 8'h20;
        send_frame(d, c, '0, d, 1'b1, 1'b0);
        recv("chk_err", 0, 1'b0);

        // 4 Double data error, bits 0 and 9: raw received word delivered
        d = 14'h1234;
        send_frame(d, chk_calc(d), 22'h000201, 14'h1235 ^ 14'h0200, 1'b0, 1'b1);
        recv("double_err", 0, 1'b0);

        // 5 Abort after 10 bits, then a full clean frame
        send_bits({8'hFF, 14'h3FFF}, 10);
        check("abort_before", abort_cnt, 0);
        d = 14'h0F0F;
        send_frame(d, chk_calc(d), '0, d, 1'b0, 1'b0);
        check("abort_count", abort_cnt, 1);
        recv("abort_frame", 0, 1'b0);
        check("abort_sb_empty", sb_q.size(), 0);

        // 6 Backpressure with ignored input beats, then reset mid-SHIFT
        d = 14'h2222;
        send_frame(d, chk_calc(d), '0, d, 1'b0, 1'b0);
        recv("stall", 5, 1'b1);
        check("stall_abort_unchanged", abort_cnt, 1);
        d = 14'h1111;
        send_bits({chk_calc(d), d}, 8);
        rst = 1'b1;
        #1;
        check("midrst_mvalid", m_valid, 0);
        check("midrst_sready", s_ready, 1);
        check("midrst_abort", abort_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d = 14'h1555;
        send_frame(d, chk_calc(d), '0, d, 1'b0, 1'b0);
        recv("post_rst", 0, 1'b0);
        check("post_rst_abort", abort_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
